fir_filter_mac: RTL and testbench

FIR_FILTER_MAC -- requirements
Module: fir_filter_mac

---
 rtl/fir_filter_mac.sv | 183 ++++++++++++++++++
 tb/tb_fir_filter_mac.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mac.sv
// ============================================================================
// Module      : fir_filter_mac
// Description : Time-multiplexed FIR filter. A single shared multiplier
//               evaluates y[n] = sum c[k]*x[n-k] over a TAPS-deep circular
//               delay line, one product per cycle, into a full-precision
//               accumulator. The result is rounded, shifted and saturated.
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               in_data   - signed input sample (WIDTH)
//               in_valid  - in_data valid
//               in_ready  - high only while idle; accept on valid & ready
//               out_data  - signed filtered sample, held until next result
//               out_valid - one-cycle strobe for a new out_data
//               coef_we   - coefficient write enable (honoured only in idle)
//               coef_addr - tap index k
//               coef_data - signed coefficient c[k]
//               coef_err  - one-cycle strobe, registered: high in the cycle
//                           after a coef_we that arrived while busy
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_filter_mac #(
    parameter int WIDTH      = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 128,
    parameter int SHIFT      = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [WIDTH-1:0]      in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [WIDTH-1:0]      out_data,
    output logic                         out_valid,
    input  logic                         coef_we,
    input  logic [$clog2(TAPS)-1:0]      coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data,
    output logic                         coef_err
);

    localparam int c_AW   = $clog2(TAPS);
    localparam int c_PW   = WIDTH + COEF_WIDTH;
    localparam int c_ACCW = c_PW + c_AW;
    // One spare bit so the rounding add can never wrap.
    localparam int c_RW   = c_ACCW + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_MAC   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [c_AW-1:0] c_ONE  = {{(c_AW-1){1'b0}}, 1'b1};
    localparam logic [c_AW-1:0] c_LAST = {c_AW{1'b1}};

    localparam logic signed [c_RW-1:0] c_SAT_MAX = {{(c_RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_RW-1:0] c_SAT_MIN = {{(c_RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [1:0]                   r_state;
    logic [c_AW-1:0]              r_wptr;
    logic [c_AW-1:0]              r_k;
    logic signed [WIDTH-1:0]      r_dline [TAPS];
    logic signed [COEF_WIDTH-1:0] r_coef  [TAPS];
    logic signed [c_PW-1:0]       r_prod;
    logic                         r_prod_vld;
    logic signed [c_ACCW-1:0]     r_acc;
    logic signed [WIDTH-1:0]      r_out_data;
    logic                         r_out_valid;
    logic                         r_coef_err;

    logic [c_AW-1:0]              w_raddr;
    logic signed [c_PW-1:0]       w_prod;
    logic signed [c_RW-1:0]       w_rnd;
    logic signed [c_RW-1:0]       w_shf;
    logic signed [WIDTH-1:0]      w_sat;

    // The pointer has already advanced past the newest sample, so tap k
    // lives at (wptr - 1 - k) modulo TAPS.
    assign w_raddr = r_wptr - c_ONE - r_k;
    assign w_prod  = c_PW'(r_coef[r_k]) * c_PW'(r_dline[w_raddr]);

    generate
        if (SHIFT > 0) begin : g_rnd
            assign w_rnd = c_RW'(r_acc) + (c_RW'(1) <<< (SHIFT - 1));
        end else begin : g_no_rnd
            assign w_rnd = c_RW'(r_acc);
        end
    endgenerate

    assign w_shf = w_rnd >>> SHIFT;

    always_comb begin
        w_sat = w_shf[WIDTH-1:0];
        if (w_shf > c_SAT_MAX) begin
            w_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (w_shf < c_SAT_MIN) begin
            w_sat = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_wptr      <= '0;
            r_k         <= '0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_coef_err  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_dline[i] <= '0;
                r_coef[i]  <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_coef_err  <= 1'b0;

            // Two-stage datapath: product register, then accumulate.
            r_prod     <= w_prod;
            r_prod_vld <= (r_state == c_MAC);
            if (r_prod_vld) begin
                r_acc <= r_acc + c_ACCW'(r_prod);
            end

            // A write in the accepting cycle lands before the first product
            // is read, so it already applies to that sample.
            if (coef_we) begin
                if (r_state == c_IDLE) begin
                    r_coef[coef_addr] <= coef_data;
                end else begin
                    r_coef_err <= 1'b1;
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_dline[r_wptr] <= in_data;
                        r_wptr          <= r_wptr + c_ONE;
                        r_acc           <= '0;
                        r_k             <= '0;
                        r_state         <= c_MAC;
                    end
                end
                c_MAC: begin
                    if (r_k == c_LAST) begin
                        r_k     <= '0;
                        r_state <= c_FLUSH;
                    end else begin
                        r_k <= r_k + c_ONE;
                    end
                end
                c_FLUSH: begin
                    // Cycle 0 lets the last product reach the accumulator,
                    // cycle 1 captures the finished sum.
                    if (r_k == c_ONE) begin
                        r_out_data  <= w_sat;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end else begin
                        r_k <= r_k + c_ONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign coef_err  = r_coef_err;

endmodule

`default_nettype wire

// File: tb/tb_fir_filter_mac.sv
// ============================================================================
// Module      : tb_fir_filter_mac
// Description : Self-checking bench for fir_filter_mac. Instance A uses
//               TAPS=8, SHIFT=0; instance B uses the defaults (TAPS=128,
//               SHIFT=12). A shared stimulus bus is steered by sel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_filter_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n_a, rst_n_b, sel;
    logic signed [15:0] in_data, coef_data;
    logic               in_valid, coef_we;
    logic [7:0]         coef_addr;

    logic               a_in_ready, a_out_valid, a_coef_err;
    logic signed [15:0] a_out_data;
    logic               b_in_ready, b_out_valid, b_coef_err;
    logic signed [15:0] b_out_data;

    logic               m_in_ready, m_out_valid, m_coef_err;
    logic signed [15:0] m_out_data;

    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_coef_err  = sel ? b_coef_err  : a_coef_err;
    assign m_out_data  = sel ? b_out_data  : a_out_data;

    fir_filter_mac #(.WIDTH(16), .COEF_WIDTH(16), .TAPS(8), .SHIFT(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a),
        .in_data(in_data), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid),
        .coef_we(coef_we & ~sel), .coef_addr(coef_addr[2:0]), .coef_data(coef_data),
        .coef_err(a_coef_err)
    );

    fir_filter_mac u_dut_b (
        .clk(clk), .rst_n(rst_n_b),
        .in_data(in_data), .in_valid(in_valid & sel), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid),
        .coef_we(coef_we & sel), .coef_addr(coef_addr[6:0]), .coef_data(coef_data),
        .coef_err(b_coef_err)
    );

    // Reference model: coefficient tables and newest-first sample history.
    int coef_m [2][256];
    int hist_m [2][256];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int x; int y; } vec_t;
    vec_t imp_tbl[$];
    vec_t sat_tbl[$];
    int   acc_c[$];
    int   out_c[$];

    function automatic int taps_of(input int s);
        return (s != 0) ? 128 : 8;
    endfunction

    function automatic void hpush(input int s, input int x);
        for (int k = 255; k > 0; k--) hist_m[s][k] = hist_m[s][k-1];
        hist_m[s][0] = x;
    endfunction

    function automatic void model_clear(input int s);
        for (int k = 0; k < 256; k++) begin
            hist_m[s][k] = 0;
            coef_m[s][k] = 0;
        end
    endfunction

    function automatic int model_y(input int s);
        longint acc = 0;
        int     sh  = (s != 0) ? 12 : 0;
        for (int k = 0; k < taps_of(s); k++)
            acc += longint'(coef_m[s][k]) * longint'(hist_m[s][k]);
        if (sh > 0) acc += longint'(1) << (sh - 1);
        acc = acc >>> sh;
        if (acc > 32767)  return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wcoef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 8'(a);
        coef_data = 16'(d);
        @(negedge clk);
        coef_we = 1'b0;
        coef_m[sel][a] = d;
        check("idle_write_no_err", m_coef_err, 0);
    endtask

    // Push one sample (optionally with a same-cycle coefficient write),
    // wait for the result and check latency, value, strobe width and hold.
    task automatic push(input int x, input bit cw, input int ca, input int cd, output int y);
        int t = 0;
        while (!m_in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", m_in_ready, 1);
        in_data  = 16'(x);
        in_valid = 1'b1;
        if (cw) begin
            coef_we   = 1'b1;
            coef_addr = 8'(ca);
            coef_data = 16'(cd);
            coef_m[sel][ca] = cd;
        end
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        hpush(int'(sel), x);
        t = 1;
        while (!m_out_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("latency", t, taps_of(int'(sel)) + 3);
        y = int'(m_out_data);
        check("out_data", y, model_y(int'(sel)));
        @(negedge clk);
        check("strobe_one_cycle", m_out_valid, 0);
        check("out_hold", m_out_data, y);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  y, t;
        bit  seen;

        for (int i = 0; i < 8; i++) imp_tbl.push_back('{(i == 0) ? 1 : 0, i + 1});
        imp_tbl.push_back('{0, 0});
        for (int i = 0; i < 8; i++) sat_tbl.push_back('{32767, 32767});
        for (int i = 1; i <= 8; i++) sat_tbl.push_back('{-32768, (i < 4) ? 32767 : -32768});

        model_clear(0);
        model_clear(1);
        sel = 1'b0; in_data = '0; in_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready_a", a_in_ready, 1);
        check("rst_in_ready_b", b_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_coef_err", a_coef_err, 0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);

        // Impulse response, coefficients 1..8.
        for (int k = 0; k < 8; k++) wcoef(k, k + 1);
        foreach (imp_tbl[i]) begin
            push(imp_tbl[i].x, 1'b0, 0, 0, y);
            check("impulse", y, imp_tbl[i].y);
        end

        // in_valid held high: accepts every TAPS+4, results TAPS+3 later.
        in_data = '0; in_valid = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (m_in_ready && in_valid) begin
                acc_c.push_back(c);
                hpush(0, 0);
            end
            if (m_out_valid) begin
                out_c.push_back(c);
                check("hs_out_data", m_out_data, model_y(0));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("hs_accepts", acc_c.size(), 3);
        check("hs_outs", out_c.size(), 3);
        if (acc_c.size() == 3 && out_c.size() == 3) begin
            check("hs_spacing_1", acc_c[1] - acc_c[0], 12);
            check("hs_spacing_2", acc_c[2] - acc_c[1], 12);
            for (int i = 0; i < 3; i++) check("hs_latency", out_c[i] - acc_c[i], 11);
        end

        // coef_we during MAC is dropped and flagged.
        in_data = 16'sd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        hpush(0, 1);
        coef_we = 1'b1; coef_addr = 8'd3; coef_data = 16'sd555;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_err_pulse", a_coef_err, 1);
        @(negedge clk);
        check("coef_err_clear", a_coef_err, 0);
        t = 3;
        while (!a_out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("busy_write_latency", t, 11);
        check("busy_write_out", a_out_data, 1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, 0, 0, y);
            check("busy_write_unchanged", y, i + 2);
        end

        // Same-cycle coefficient write and sample: 10*2 + c[4]*1.
        push(2, 1'b1, 0, 10, y);
        check("coef_write_priority", y, 25);

        // Saturation.
        for (int k = 0; k < 8; k++) wcoef(k, 32767);
        foreach (sat_tbl[i]) begin
            push(sat_tbl[i].x, 1'b0, 0, 0, y);
            check("saturation", y, sat_tbl[i].y);
        end

        // Reset in the middle of MAC.
        in_data = 16'sd1000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_a = 1'b0;
        #1;
        check("midrst_in_ready", a_in_ready, 1);
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_out_data", a_out_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n_a = 1'b1;
        model_clear(0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (a_out_valid) seen = 1'b1;
        end
        check("midrst_no_out_valid", seen, 0);
        for (int k = 0; k < 8; k++) wcoef(k, k + 1);
        foreach (imp_tbl[i]) begin
            push(imp_tbl[i].x, 1'b0, 0, 0, y);
            check("post_reset_impulse", y, imp_tbl[i].y);
        end

        // Random traffic on A.
        for (int k = 0; k < 8; k++) wcoef(k, int'($urandom_range(0, 16)) - 8);
        for (int i = 0; i < 24; i++)
            push(int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 16)) - 8, y);

        // DC on B: settles at 100.
        sel = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 128; k++) wcoef(k, 32);
        for (int i = 0; i < 130; i++) push(100, 1'b0, 0, 0, y);
        check("dc_settle", y, 100);

        // Random traffic on B.
        for (int k = 0; k < 128; k++) wcoef(k, int'($urandom_range(0, 400)) - 200);
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0)
                push(int'($urandom_range(0, 65535)) - 32768, 1'b0, 0, 0, y);
            else
                push(int'($urandom_range(0, 4000)) - 2000, ($urandom_range(0, 2) == 0),
                     int'($urandom_range(0, 127)), int'($urandom_range(0, 400)) - 200, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
